// File: rtl/stack_pkg.sv
// Shared codes for the stack host driver: bus commands, request ops and FSM states.
package stack_pkg;

  localparam int STACK_DEPTH = 5;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_PUSH  = 2'b01,
    OP_POP   = 2'b10,
    OP_GET   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    IDLE = 2'b01,
    CMD  = 2'b10,
    DONE = 2'b11
  } state_e;

  // CLEAR is carried by the responder reset line, so it travels as a NOP.
  function automatic cmd_e op_to_cmd(input op_e op);
    case (op)
      OP_PUSH: op_to_cmd = CMD_PUSH;
      OP_POP:  op_to_cmd = CMD_POP;
      OP_GET:  op_to_cmd = CMD_GET;
      default: op_to_cmd = CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/stack_host_driver_if.sv
// Upstream request/response handshake between a requester and the stack host driver.
interface stack_host_driver_if #(
  parameter int DW = 4,
  parameter int IW = 3
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic [IW-1:0] req_index;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_op, req_data, req_index,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_data, req_index,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_bus_io.sv
// Stack-side pins: negedge-launched command/index/data, tristate data driver and
// the CLK-high read capture latch.
module stack_bus_io
  import stack_pkg::*;
#(
  parameter int DW = 4,
  parameter int IW = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  state_e        state,
  input  op_e           op,
  input  logic [DW-1:0] data,
  input  logic [IW-1:0] index,
  output logic          stk_reset,
  output logic [1:0]    stk_command,
  output logic [IW-1:0] stk_index,
  inout  wire  [DW-1:0] io_data,
  output logic [DW-1:0] cap_data
);

  logic          drive_en;
  logic          cap_en;
  logic [DW-1:0] dout;

  // Launch on the falling edge so the responder sees half a cycle of setup.
  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      stk_reset   <= 1'b1;
      stk_command <= CMD_NOP;
      stk_index   <= '0;
      drive_en    <= 1'b0;
      cap_en      <= 1'b0;
      dout        <= '0;
    end else begin
      stk_reset   <= 1'b0;
      stk_command <= CMD_NOP;
      stk_index   <= '0;
      drive_en    <= 1'b0;
      cap_en      <= 1'b0;
      if (state == CMD) begin
        stk_command <= op_to_cmd(op);
        stk_reset   <= (op == OP_CLEAR);
        stk_index   <= index;
        drive_en    <= (op == OP_PUSH);
        cap_en      <= (op == OP_POP) || (op == OP_GET);
        dout        <= data;
      end
    end
  end

  assign io_data = drive_en ? dout : 'z;

  // Closes on the same CLK fall that ends the responder's drive window.
  always_latch begin
    if (CLK && cap_en) cap_data <= io_data;
  end

endmodule

// File: rtl/stack_host_driver.sv
// Initiator-side driver for the 5-entry stack responder, with shadow depth
// tracking and a one-cycle response pulse per request.
//   state | meaning
//   INIT  | one cycle after reset: responder sees NOP with its reset released
//   IDLE  | ready for a request
//   CMD   | command launched at the negedge, responder samples at next posedge
//   DONE  | read data captured while CLK high, NOP launched, response at posedge
module stack_host_driver
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int DW    = 4,
  parameter int IW    = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  stack_host_driver_if.slave host,
  output logic [2:0]    depth,
  output logic          STK_RESET,
  output logic [1:0]    STK_COMMAND,
  output logic [IW-1:0] STK_INDEX,
  inout  wire  [DW-1:0] IO_DATA
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  state_e        state;
  op_e           op_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] idx_q;
  logic [DW-1:0] cap_data;
  logic          accept;

  assign accept = host.req_valid && host.req_ready;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= INIT;
      op_q           <= OP_CLEAR;
      data_q         <= '0;
      idx_q          <= '0;
      depth          <= '0;
      host.req_ready <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.rsp_err   <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      if (accept) begin
        op_q   <= op_e'(host.req_op);
        data_q <= host.req_data;
        idx_q  <= host.req_index;
      end
      case (state)
        INIT: begin
          state          <= IDLE;
          host.req_ready <= 1'b1;
        end
        IDLE: begin
          if (accept) begin
            state          <= CMD;
            host.req_ready <= 1'b0;
          end
        end
        CMD: begin
          state          <= DONE;
          host.req_ready <= 1'b1;
        end
        DONE: begin
          host.rsp_valid <= 1'b1;
          case (op_q)
            OP_CLEAR: begin
              depth         <= '0;
              host.rsp_data <= '0;
              host.rsp_err  <= 1'b0;
            end
            OP_PUSH: begin
              host.rsp_data <= '0;
              host.rsp_err  <= (depth >= DEPTH_L);
              if (depth < DEPTH_L) depth <= depth + 3'd1;
            end
            OP_POP: begin
              host.rsp_data <= cap_data;
              host.rsp_err  <= (depth == 3'd0);
              if (depth != 3'd0) depth <= depth - 3'd1;
            end
            default: begin
              host.rsp_data <= cap_data;
              host.rsp_err  <= (32'(idx_q) >= 32'(depth)) || (32'(idx_q) >= 32'(DEPTH));
            end
          endcase
          // A request waiting here goes straight back out: one op per two cycles.
          if (accept) begin
            state          <= CMD;
            host.req_ready <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  stack_bus_io #(.DW(DW), .IW(IW)) u_bus_io (
    .CLK         (CLK),
    .RESET       (RESET),
    .state       (state),
    .op          (op_q),
    .data        (data_q),
    .index       (idx_q),
    .stk_reset   (STK_RESET),
    .stk_command (STK_COMMAND),
    .stk_index   (STK_INDEX),
    .io_data     (IO_DATA),
    .cap_data    (cap_data)
  );

endmodule

// File: tb/tb_stack_host_driver.sv
// Directed bench for stack_host_driver with a behavioural 5-entry stack responder.
module tb_stack_host_driver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] depth;
  logic       STK_RESET;
  logic [1:0] STK_COMMAND;
  logic [2:0] STK_INDEX;
  wire  [3:0] IO_DATA;

  int n_cmp = 0;
  int n_bad = 0;
  int n_conflict = 0;
  int n_xbus = 0;

  stack_host_driver_if #(.DW(4), .IW(3)) bus ();

  stack_host_driver dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .host        (bus),
    .depth       (depth),
    .STK_RESET   (STK_RESET),
    .STK_COMMAND (STK_COMMAND),
    .STK_INDEX   (STK_INDEX),
    .IO_DATA     (IO_DATA)
  );

  always #5 CLK = ~CLK;

  // Responder: samples at posedge, drives read data only while CLK is high.
  logic [3:0] mem [5];
  logic       roe = 1'b0;
  logic [3:0] rdout = 4'h0;

  initial for (int i = 0; i < 5; i++) mem[i] = 4'h0;

  assign IO_DATA = (roe && CLK) ? rdout : 4'bzzzz;

  always @(posedge CLK) begin
    roe <= 1'b0;
    if (!STK_RESET) begin
      case (STK_COMMAND)
        2'b01: begin
          for (int i = 4; i > 0; i--) mem[i] <= mem[i-1];
          mem[0] <= IO_DATA;
        end
        2'b10: begin
          rdout <= mem[0];
          for (int i = 0; i < 4; i++) mem[i] <= mem[i+1];
          roe <= 1'b1;
        end
        2'b11: begin
          rdout <= (STK_INDEX < 3'd5) ? mem[STK_INDEX] : 4'h0;
          roe   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The host drives the bus exactly while PUSH is on STK_COMMAND.
  always @(posedge CLK or negedge CLK) begin
    #1;
    if (roe && CLK && STK_COMMAND == 2'b01) n_conflict++;
  end

  always @(posedge CLK) begin
    if (STK_COMMAND == 2'b01 && $isunknown(IO_DATA)) n_xbus++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] d,
                        input logic [2:0] idx, input logic [3:0] exp_data,
                        input logic exp_err, input logic [2:0] exp_depth, input bit chk_data);
    int n;
    logic [1:0] exp_cmd;
    exp_cmd = (op == 2'b00) ? 2'b00 : op;
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d; bus.req_index = idx;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "/accept_in_time"}, 32'(n < 20), 32'd1);
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(negedge CLK); #1;
    chk({tag, "/cmd"}, 32'(STK_COMMAND), 32'(exp_cmd));
    chk({tag, "/stk_reset_cmd"}, 32'(STK_RESET), 32'(op == 2'b00));
    chk({tag, "/index"}, 32'(STK_INDEX), 32'(idx));
    @(posedge CLK); #1;
    chk({tag, "/no_early_rsp"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge CLK); #1;
    chk({tag, "/nop_in_done"}, 32'(STK_COMMAND), 32'd0);
    @(posedge CLK); #1;
    chk({tag, "/rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (chk_data) chk({tag, "/rsp_data"}, 32'(bus.rsp_data), 32'(exp_data));
    chk({tag, "/rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    chk({tag, "/depth"}, 32'(depth), 32'(exp_depth));
    chk({tag, "/ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_data = 4'h0; bus.req_index = 3'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst/req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst/rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst/rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst/depth", 32'(depth), 32'd0);
    chk("rst/cmd", 32'(STK_COMMAND), 32'd0);
    chk("rst/index", 32'(STK_INDEX), 32'd0);
    chk("rst/stk_reset", 32'(STK_RESET), 32'd1);
    chk("rst/io_z", 32'(IO_DATA === 4'bzzzz), 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("init/ready", 32'(bus.req_ready), 32'd0);
    @(negedge CLK); #1;
    chk("init/stk_reset", 32'(STK_RESET), 32'd0);
    chk("init/cmd", 32'(STK_COMMAND), 32'd0);
    @(posedge CLK); #1;
    chk("idle/ready", 32'(bus.req_ready), 32'd1);

    run_op("push3", 2'b01, 4'h3, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1);
    run_op("push7", 2'b01, 4'h7, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1);
    run_op("push9", 2'b01, 4'h9, 3'd0, 4'h0, 1'b0, 3'd3, 1'b1);
    run_op("pop9", 2'b10, 4'h0, 3'd0, 4'h9, 1'b0, 3'd2, 1'b1);
    run_op("pop7", 2'b10, 4'h0, 3'd0, 4'h7, 1'b0, 3'd1, 1'b1);
    run_op("pop3", 2'b10, 4'h0, 3'd0, 4'h3, 1'b0, 3'd0, 1'b1);
    run_op("pop_empty", 2'b10, 4'h0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);

    run_op("fill1", 2'b01, 4'h1, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1);
    run_op("fill2", 2'b01, 4'h2, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1);
    run_op("fill3", 2'b01, 4'h3, 3'd0, 4'h0, 1'b0, 3'd3, 1'b1);
    run_op("fill4", 2'b01, 4'h4, 3'd0, 4'h0, 1'b0, 3'd4, 1'b1);
    run_op("fill5", 2'b01, 4'h5, 3'd0, 4'h0, 1'b0, 3'd5, 1'b1);
    run_op("overflow6", 2'b01, 4'h6, 3'd0, 4'h0, 1'b1, 3'd5, 1'b1);
    run_op("get0_full", 2'b11, 4'h0, 3'd0, 4'h6, 1'b0, 3'd5, 1'b1);
    run_op("get4_full", 2'b11, 4'h0, 3'd4, 4'h2, 1'b0, 3'd5, 1'b1);
    run_op("get5_range", 2'b11, 4'h0, 3'd5, 4'h0, 1'b1, 3'd5, 1'b0);
    run_op("clear", 2'b00, 4'hF, 3'd0, 4'h0, 1'b0, 3'd0, 1'b1);

    run_op("push5", 2'b01, 4'h5, 3'd0, 4'h0, 1'b0, 3'd1, 1'b1);
    run_op("pushA", 2'b01, 4'hA, 3'd0, 4'h0, 1'b0, 3'd2, 1'b1);
    run_op("get1", 2'b11, 4'h0, 3'd1, 4'h5, 1'b0, 3'd2, 1'b1);
    run_op("get3_err", 2'b11, 4'h0, 3'd3, 4'h0, 1'b1, 3'd2, 1'b0);

    // Back-to-back POP then PUSH B with req_valid held high.
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_op = 2'b10; bus.req_data = 4'h0; bus.req_index = 3'd0;
    @(posedge CLK); #1;
    chk("b2b/pop_taken", 32'(bus.req_ready), 32'd0);
    bus.req_op = 2'b01; bus.req_data = 4'hB;
    @(posedge CLK); #1;
    chk("b2b/e1_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge CLK); #1;
    chk("b2b/pop_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b/pop_data", 32'(bus.rsp_data), 32'hA);
    chk("b2b/pop_depth", 32'(depth), 32'd1);
    chk("b2b/push_taken_e2", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    @(negedge CLK); #1;
    chk("b2b/push_cmd", 32'(STK_COMMAND), 32'd1);
    @(posedge CLK); #1;
    chk("b2b/push_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge CLK); #1;
    chk("b2b/push_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b/push_err", 32'(bus.rsp_err), 32'd0);
    chk("b2b/push_depth", 32'(depth), 32'd2);
    run_op("getB", 2'b11, 4'h0, 3'd0, 4'hB, 1'b0, 3'd2, 1'b1);

    // RESET in the middle of a PUSH while the host is driving the bus.
    @(negedge CLK);
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_data = 4'hC; bus.req_index = 3'd0;
    @(posedge CLK); #1;
    bus.req_valid = 1'b0;
    @(negedge CLK); #1;
    chk("rstmid/driving", 32'(STK_COMMAND), 32'd1);
    #1 RESET = 1'b1;
    #1;
    chk("rstmid/io_z", 32'(IO_DATA === 4'bzzzz), 32'd1);
    chk("rstmid/stk_reset", 32'(STK_RESET), 32'd1);
    chk("rstmid/cmd_nop", 32'(STK_COMMAND), 32'd0);
    chk("rstmid/depth", 32'(depth), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rstmid/no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_data = 4'h7; bus.req_index = 3'd0;
    chk("rstmid/init_ready", 32'(bus.req_ready), 32'd0);
    @(negedge CLK); #1;
    chk("rstmid/init_stk_reset", 32'(STK_RESET), 32'd0);
    @(posedge CLK); #1;
    chk("rstmid/not_taken_in_init", 32'(bus.req_ready), 32'd1);
    chk("rstmid/init_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(posedge CLK); #1;
    chk("rstmid/taken_after_init", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("rstmid/first_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("rstmid/first_err", 32'(bus.rsp_err), 32'd0);
    chk("rstmid/first_depth", 32'(depth), 32'd1);

    chk("bus/no_contention", 32'(n_conflict), 32'd0);
    chk("bus/no_x_when_driven", 32'(n_xbus), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_host_driver.md
Name: stack_host_driver

Overview:
- Initiator-side driver for the 5-entry stack responder's command/bidirectional-data interface.
- Accepts PUSH/POP/GET/CLEAR requests from upstream via a valid/ready handshake and issues them on STK_COMMAND, STK_INDEX and IO_DATA.
- Handles bus turnaround and captures read data during the stack's CLK-high drive window.
- Keeps a shadow depth count and returns data plus error flags on a one-cycle response pulse.

Parameters:
- DEPTH, 5, stack entry count; must match the responder.
- DW, 4, data width.
- IW, 3, GET index width.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- req_valid  in  1  upstream request valid
- req_ready  out  1  driver can accept a request
- req_op  in  2  00 CLEAR, 01 PUSH, 10 POP, 11 GET
- req_data  in  DW  PUSH data
- req_index  in  IW  GET depth (0 = top)
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DW  POP/GET data; 0 for PUSH/CLEAR
- rsp_err  out  1  overflow, underflow or index error on this op
- depth  out  3  shadow occupancy, 0..DEPTH
- STK_RESET  out  1  to responder RESET
- STK_COMMAND  out  2  00 NOP, 01 PUSH, 10 POP, 11 GET
- STK_INDEX  out  IW  to responder INDEX
- IO_DATA  inout  DW  shared data bus

Behaviour:
- Reset, while RESET=1:
  - State INIT; req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, depth=0.
  - STK_COMMAND=NOP, STK_INDEX=0, STK_RESET=1, IO_DATA=Z.
- INIT:
  - Lasts exactly one CLK after RESET falls, with STK_RESET=0 and NOP driven.
  - This clears the responder's output-enable, which has no reset of its own.
  - Then goes to IDLE.
- State transitions on posedge; stack-side outputs update on negedge, giving half-cycle setup before the responder samples at posedge.
- IDLE:
  - req_ready=1.
  - Handshake at posedge E0 when req_valid&&req_ready; latches op/data/index and goes to CMD.
- CMD:
  - req_ready=0.
  - At the negedge inside CMD, drives STK_COMMAND=op (CLEAR drives NOP and STK_RESET=1) and STK_INDEX.
  - For PUSH, also drives IO_DATA=data.
  - Responder samples at E1; goes to DONE.
- DONE:
  - While CLK=1, a transparent-high capture latch follows IO_DATA (POP/GET only) and holds once CLK falls. No negedge flop is used, to avoid the release race.
  - At the negedge inside DONE: STK_COMMAND=NOP, STK_RESET=0, IO_DATA=Z.
  - At E2: rsp_valid=1 for one cycle, rsp_data/rsp_err/depth updated, back to IDLE.
- Latency and throughput:
  - Accept at E0 gives rsp_valid high E2..E3.
  - Next accept is possible at E2, so one op per 2 CLK.
  - The mandatory NOP in DONE guarantees turnaround: the responder is never driving when a following PUSH puts data on the bus.
- Depth and error rules:
  - PUSH, depth<DEPTH: depth+1, err=0.
  - PUSH, depth==DEPTH: issued anyway (responder overwrites oldest), depth stays DEPTH, err=1.
  - POP, depth>0: depth-1.
  - POP, depth==0: issued anyway, returns stale data, depth stays 0, err=1.
  - GET: err=1 if index>=depth or index>=DEPTH; still issued and data returned; depth unchanged.
  - CLEAR: depth=0, rsp_data=0, err=0.
- IO_DATA is driven only in the second half of CMD and the first half of DONE for PUSH; Z at all other times.
- RESET asserted mid-operation:
  - Immediate return to INIT state; any in-flight response is dropped (no rsp_valid).
  - IO_DATA released and STK_RESET=1 asynchronously.
- req_valid while req_ready=0: ignored; upstream holds the request.

Decomposition:
- Package stack_pkg:
  - Bus command codes CMD_NOP/PUSH/POP/GET.
  - Request op codes OP_CLEAR/PUSH/POP/GET.
  - STACK_DEPTH=5.
  - FSM state enum INIT/IDLE/CMD/DONE.
- One sub-module, stack_bus_io:
  - Tristate driver, negedge output registers and the CLK-high capture latch.
  - Keeps the mixed-edge logic out of the FSM.

Test Plan:
- Reset, then PUSH 3,7,9, then POP ×3:
  - rsp_data 9,7,3, err=0 each; depth 3→0.
  - IO_DATA never X at any posedge.
- POP at depth 0 -> rsp_err=1, depth stays 0, req_ready returns at E2.
- PUSH 1..6 -> sixth rsp_err=1, depth=5; then GET index 0 returns 6 and GET index 4 returns 2.
- After PUSH 5,A, issue GET index 1 -> rsp_data=5, err=0; then GET index 3 -> err=1.
- Back-to-back POP then PUSH B with req_valid held high:
  - POP returns top, PUSH accepted 2 cycles later.
  - Monitor shows no cycle where both sides drive IO_DATA.
- Assert RESET in CMD of a PUSH:
  - No rsp_valid, IO_DATA=Z immediately, depth=0.
  - First request accepted only after one INIT cycle following RESET release.
